// File: rtl/tlul_sram_bridge.sv
// TL-UL device bridge in front of a single-port SRAM with one-cycle read latency.
// Optional response integrity: define TLUL_SRAM_BRIDGE_INTG_EN.

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_sram_bridge
  import tlul_pkg::*;
#(
  parameter int AW    = 12,
  parameter int Depth = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  tl_h2d_t       tl_i,
  output tl_d2h_t       tl_o,
  output logic          sram_req_o,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  output logic [3:0]    sram_be_o,
  input  logic [31:0]   sram_rdata_i
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = $clog2(Depth);

  typedef struct packed {
    logic       is_get;
    logic       err;
    logic [7:0] source;
    logic [1:0] size;
  } s1_t;

  typedef struct packed {
    logic        is_get;
    logic        err;
    logic [7:0]  source;
    logic [1:0]  size;
    logic [31:0] data;
  } rsp_t;

  logic            a_ready, a_err, a_is_get, a_is_put, accept;
  logic            s1_valid;
  s1_t             s1_q;
  logic            push, pop, d_valid;
  rsp_t            push_rsp, head;
  rsp_t            mem [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] count;
  logic [CntW:0]   occupancy;
  logic [31:0]     d_data;

  logic unused_param;
  assign unused_param = ^tl_i.a_param;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // ---------------- A channel: accept, check, drive SRAM ----------------
  assign a_is_get = (tl_i.a_opcode == Get);
  assign a_is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    a_err = 1'b0;
    if (!(a_is_get || a_is_put))                             a_err = 1'b1;
    if (tl_i.a_size == 2'd3)                                 a_err = 1'b1;
    if (tl_i.a_size == 2'd1 && tl_i.a_address[0])            a_err = 1'b1;
    if (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] != 2'b00) a_err = 1'b1;
    if (tl_i.a_address[31:AW+2] != '0)                       a_err = 1'b1;
  end

  // A slot is reserved for anything in s1 so the FIFO can never overflow.
  assign occupancy = {1'b0, count} + {{CntW{1'b0}}, s1_valid};
  assign a_ready   = rst_ni && (occupancy < (CntW + 1)'(Depth));
  assign accept    = tl_i.a_valid && a_ready;

  assign sram_req_o   = accept && !a_err;
  assign sram_we_o    = a_is_put;
  assign sram_addr_o  = tl_i.a_address[AW+1:2];
  assign sram_wdata_o = tl_i.a_data;
  assign sram_be_o    = a_is_get ? 4'hf : tl_i.a_mask;

  // ---------------- Stage s1: waits for the SRAM read data ----------------
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) s1_valid <= 1'b0;
    else         s1_valid <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_q.is_get <= a_is_get;
      s1_q.err    <= a_err;
      s1_q.source <= tl_i.a_source;
      s1_q.size   <= tl_i.a_size;
    end
  end

  // ---------------- Response FIFO ----------------
  assign push = s1_valid;
  assign pop  = d_valid && tl_i.d_ready;

  always_comb begin
    push_rsp.is_get = s1_q.is_get;
    push_rsp.err    = s1_q.err;
    push_rsp.source = s1_q.source;
    push_rsp.size   = s1_q.size;
    push_rsp.data   = '0;
    if (s1_q.is_get) push_rsp.data = s1_q.err ? 32'hFFFF_FFFF : sram_rdata_i;
  end

  // NOTE: storage is not reset; outputs are masked by d_valid so stale entries never leak.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_rsp;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- D channel ----------------
  assign head    = mem[rd_ptr];
  assign d_valid = (count != '0);
  assign d_data  = d_valid ? head.data : '0;

`ifdef TLUL_SRAM_BRIDGE_INTG_EN
  logic [38:0] data_enc;
  logic [63:0] rsp_enc;
  logic [2:0]  rsp_opcode;
  assign rsp_opcode = head.is_get ? AccessAckData : AccessAck;
  assign data_enc   = prim_secded_pkg::prim_secded_inv_39_32_enc(d_data);
  assign rsp_enc    = prim_secded_pkg::prim_secded_inv_64_57_enc(
                        57'({rsp_opcode, head.size, head.source, head.err}));
`endif

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    tl_o.d_valid = d_valid;
    tl_o.d_data  = d_data;
    if (d_valid) begin
      tl_o.d_opcode = head.is_get ? AccessAckData : AccessAck;
      tl_o.d_size   = head.size;
      tl_o.d_source = head.source;
      tl_o.d_error  = head.err;
`ifdef TLUL_SRAM_BRIDGE_INTG_EN
      tl_o.d_user.data_intg = data_enc[38:32];
      tl_o.d_user.rsp_intg  = rsp_enc[63:57];
`endif
    end
  end

endmodule

// File: tb/tb_tlul_sram_bridge.sv
// Scoreboard bench for tlul_sram_bridge: a reference model queues expected
// responses at request acceptance; a monitor compares them as the D channel fires.

module tb_tlul_sram_bridge;
  import tlul_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  tl_h2d_t       a_drv, tl_i;
  logic          d_ready_tb = 1'b1;
  tl_d2h_t       tl_o;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [3:0]    sram_be;

  always #5 clk = ~clk;

  always_comb begin
    tl_i         = a_drv;
    tl_i.d_ready = d_ready_tb;
  end

  tlul_sram_bridge #(.AW(AW), .Depth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tl_i         (tl_i),
    .tl_o         (tl_o),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata)
  );

  // Synchronous SRAM with one-cycle read latency.
  logic [31:0] sram_mem [2**AW];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // d_ready policy: 0 = low, 1 = high, 2 = random.
  int dr_mode = 1;
  always @(posedge clk) begin
    #2;
    case (dr_mode)
      0:       d_ready_tb = 1'b0;
      1:       d_ready_tb = 1'b1;
      default: d_ready_tb = ($urandom_range(0, 3) != 0);
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Reference model ----------------
  typedef struct {
    logic [2:0]  opcode;
    logic [7:0]  source;
    logic [1:0]  size;
    logic        err;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [2**AW];

  function automatic bit ref_err(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr);
    bit ok_op    = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    bit aligned  = (size < 2'd3) && ((addr % (32'd1 << size)) == 0);
    bit in_range = addr < (32'd1 << (AW + 2));
    return !(ok_op && aligned && in_range);
  endfunction

  int n_acc = 0;
  int stalls = 0;

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    bit   done = 0;
    int   tries = 0;
    int   idx;
    exp_t e;
    a_drv.a_valid   = 1'b1;
    a_drv.a_opcode  = op;
    a_drv.a_param   = 3'd0;
    a_drv.a_size    = size;
    a_drv.a_source  = src;
    a_drv.a_address = addr;
    a_drv.a_mask    = mask;
    a_drv.a_data    = data;
    while (!done) begin
      @(negedge clk);
      if (tl_o.a_ready) begin
        e.err     = ref_err(op, size, addr);
        e.opcode  = (op == 3'd4) ? 3'd1 : 3'd0;
        e.source  = src;
        e.size    = size;
        e.acc_cyc = cyc;
        e.data    = 32'h0;
        idx       = int'(addr >> 2) % (2**AW);
        if (op == 3'd4) e.data = e.err ? 32'hFFFF_FFFF : ref_mem[idx];
        else if (!e.err)
          for (int b = 0; b < 4; b++)
            if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        exp_q.push_back(e);
        check("sram_req", 32'(sram_req), 32'(!e.err));
        if (!e.err) begin
          check("sram_addr", 32'(sram_addr), addr >> 2);
          check("sram_we", 32'(sram_we), 32'(op != 3'd4));
          check("sram_be", 32'(sram_be), (op == 3'd4) ? 32'hf : 32'(mask));
          if (op != 3'd4) check("sram_wdata", sram_wdata, data);
        end
        done = 1;
        n_acc++;
      end else begin
        stalls++;
      end
      tries++;
      @(posedge clk);
      #1;
      if (!done && tries > 300) begin
        check("accept_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
    a_drv.a_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || tl_o.d_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- Monitor ----------------
  exp_t        mon_e;
  int          last_lat = -1;
  bit          tp_mode = 0;
  int          tp_pops = 0, tp_last = 0, gaps = 0;
  bit          prev_stall = 0;
  logic [31:0] held_data;
  logic [7:0]  held_source;

  always @(negedge clk) begin
    if (rst_n && tl_o.d_valid) begin
      if (prev_stall) begin
        check("d_data_stable", tl_o.d_data, held_data);
        check("d_source_stable", 32'(tl_o.d_source), 32'(held_source));
      end
      if (tl_i.d_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("d_opcode", 32'(tl_o.d_opcode), 32'(mon_e.opcode));
          check("d_source", 32'(tl_o.d_source), 32'(mon_e.source));
          check("d_size", 32'(tl_o.d_size), 32'(mon_e.size));
          check("d_error", 32'(tl_o.d_error), 32'(mon_e.err));
          check("d_data", tl_o.d_data, mon_e.data);
          check("d_param_sink", 32'({tl_o.d_param, tl_o.d_sink}), 32'd0);
`ifndef TLUL_SRAM_BRIDGE_INTG_EN
          check("d_user", 32'(tl_o.d_user), 32'd0);
`endif
          last_lat = cyc - mon_e.acc_cyc;
          if (last_lat < 2) check("latency_min", 32'(last_lat), 32'd2);
        end
        if (tp_mode) begin
          if (tp_pops > 0 && cyc != tp_last + 1) gaps++;
          tp_last = cyc;
          tp_pops++;
        end
        prev_stall = 0;
      end else begin
        prev_stall  = 1;
        held_data   = tl_o.d_data;
        held_source = tl_o.d_source;
      end
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  logic [2:0] bad_ops [5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    int          r;

    for (int i = 0; i < 2**AW; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    a_drv         = '0;
    a_drv.a_valid = 1'b1;
    a_drv.a_size  = 2'd2;
    a_drv.a_opcode = 3'd4;

    // Reset with a request pending.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_ready", 32'(tl_o.a_ready), 32'd0);
    check("rst_sram_req", 32'(sram_req), 32'd0);
    check("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    check("rst_d_error", 32'(tl_o.d_error), 32'd0);
    check("rst_d_data", tl_o.d_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    a_drv.a_valid = 1'b0;
    @(negedge clk);
    check("release_a_ready", 32'(tl_o.a_ready), 32'd1);
    @(posedge clk);
    #1;

    // Write then read back, with exact latency.
    send(3'd0, 32'h10, 2'd2, 4'hf, 32'hDEAD_BEEF, 8'd3);
    wait_drain("put");
    check("put_latency", 32'(last_lat), 32'd2);
    send(3'd4, 32'h10, 2'd2, 4'h0, 32'h0, 8'd5);
    wait_drain("get");
    check("get_latency", 32'(last_lat), 32'd2);
    send(3'd1, 32'h21, 2'd0, 4'b0010, 32'h0000_5A00, 8'd6);
    send(3'd4, 32'h20, 2'd2, 4'h0, 32'h0, 8'd7);
    wait_drain("partial");

    // Protocol errors.
    send(3'd4, 32'h2, 2'd2, 4'h0, 32'h0, 8'd8);
    send(3'd7, 32'h10, 2'd2, 4'hf, 32'h1234_5678, 8'd9);
    send(3'd4, 32'h1 << (AW + 2), 2'd2, 4'h0, 32'h0, 8'd10);
    send(3'd4, 32'h11, 2'd1, 4'h0, 32'h0, 8'd11);
    send(3'd0, 32'h10, 2'd3, 4'hf, 32'h0, 8'd12);
    wait_drain("err");

    // Back-pressure: only Depth requests fit while d_ready is low.
    dr_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    n_acc = 0;
    fork
      for (int i = 0; i < 6; i++) send(3'd4, 32'(i * 4), 2'd2, 4'h0, 32'h0, 8'(8'h20 + i));
      begin
        repeat (12) @(negedge clk);
        check("bp_accepted", 32'(n_acc), 32'(DEPTH));
        check("bp_a_ready", 32'(tl_o.a_ready), 32'd0);
        dr_mode = 1;
      end
    join
    wait_drain("bp");
    check("bp_total", 32'(n_acc), 32'd6);

    // Throughput: back-to-back Gets with d_ready held high.
    stalls  = 0;
    tp_pops = 0;
    gaps    = 0;
    tp_mode = 1;
    for (int i = 0; i < 16; i++) send(3'd4, 32'((i % 8) * 4), 2'd2, 4'h0, 32'h0, 8'(i));
    check("tp_stalls", 32'(stalls), 32'd0);
    wait_drain("tp");
    tp_mode = 0;
    check("tp_pops", 32'(tp_pops), 32'd16);
    check("tp_gaps", 32'(gaps), 32'd0);

    // Reset with responses in flight drops them all.
    dr_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    send(3'd4, 32'h10, 2'd2, 4'h0, 32'h0, 8'd40);
    send(3'd4, 32'h14, 2'd2, 4'h0, 32'h0, 8'd41);
    send(3'd4, 32'h18, 2'd2, 4'h0, 32'h0, 8'd42);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    dr_mode = 1;
    rst_n   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_reset_d_valid", 32'(tl_o.d_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized mix with random back-pressure.
    dr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      op = 3'd4;
      else if (r < 6) op = 3'd0;
      else if (r < 9) op = 3'd1;
      else            op = bad_ops[$urandom_range(0, 4)];
      size = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      addr = 32'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 3) == 0) addr = addr + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) addr = addr | (32'h1 << $urandom_range(AW + 2, 31));
      send(op, addr, size, 4'($urandom), $urandom, 8'(i));
      if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
    end
    dr_mode = 1;
    wait_drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlul_sram_bridge.md
# tlul_sram_bridge

TL-UL device-side bridge that terminates one TL-UL link from the crossbar (the downstream end of the Ibex host adapters' `tl_i_o`/`tl_d_o` traffic) and drives a single-port synchronous SRAM with fixed one-cycle read latency. It accepts Get/PutFullData/PutPartialData requests, flags protocol errors without touching the SRAM, and returns in-order responses through a small response FIFO. Instruction-fetch and data paths each get their own instance in front of boot RAM and main SRAM.

## Interface
Parameters:
- `AW`, 12: SRAM word-address width; byte address space is 2^(AW+2) bytes.
- `Depth`, 4: response FIFO entries (min 2); `Depth >= 3` sustains one request per cycle with `d_ready` held high.

Ports:
- `clk_i`  in  1  clock; only clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `tl_i`  in  `tlul_pkg::tl_h2d_t`  A-channel request and `d_ready`.
- `tl_o`  out  `tlul_pkg::tl_d2h_t`  D-channel response and `a_ready`.
- `sram_req_o`  out  1  SRAM access strobe.
- `sram_we_o`  out  1  1 = write.
- `sram_addr_o`  out  AW  word address (`a_address[AW+1:2]`).
- `sram_wdata_o`  out  32  write data.
- `sram_be_o`  out  4  byte enables (`a_mask`).
- `sram_rdata_i`  in  32  read data, valid the cycle after a read strobe.

## Operation
- Accept: A handshake when `a_valid & a_ready`. `a_ready = (fifo_count + s1_valid) < Depth`; does not depend on same-cycle `d_ready`.
- Error check (combinational on A channel), any of: opcode not Get(4)/PutFull(0)/PutPartial(1); `a_size > 2`; `a_size==1 & a_address[0]`; `a_size==2 & a_address[1:0]!=0`; `a_address[31:AW+2] != 0`.
- SRAM drive: `sram_req_o = a_valid & a_ready & !err`, same cycle as handshake; `sram_we_o` = opcode is Put*; Get drives `sram_be_o = 4'hf`.
- Stage s1 register captures {valid, is_get, err, source, size} at the accept edge.
- Cycle after s1 valid: FIFO push of {is_get, err, source, size, data}; data = `sram_rdata_i` for non-error Get, `32'hFFFF_FFFF` for error Get, 0 for Puts.
- D channel: `d_valid` = FIFO non-empty; pop on `d_valid & d_ready`. `d_opcode` = AccessAckData(1) for Get, AccessAck(0) for Puts; `d_source`, `d_size` echo request; `d_param`=0, `d_sink`=0; `d_error` = stored err.
- Ordering: strict in-order; errored requests occupy the same pipeline/FIFO slot as good ones.
- Simultaneous push and pop: count unchanged; pop from full FIFO with push in same cycle is impossible since `a_ready` already reserved the slot.
- FIFO pointers wrap modulo `Depth`; count range 0..Depth.

## Timing
- Request accepted cycle N -> SRAM strobe in N -> rdata in N+1 -> `d_valid` earliest N+2. Same 2-cycle latency for writes and errors.
- Outputs are registered except `a_ready` and SRAM strobe/address/data/be (combinational from A channel).
- `d_*` fields stable while `d_valid & !d_ready`.
- Reset (rst_ni low at clock edge): s1_valid=0, FIFO count/pointers=0, `d_valid`=0, `d_error`=0, `d_data`=0. While `rst_ni` is low, `a_ready`=0 and `sram_req_o`=0. Reset mid-transaction drops all in-flight responses; no response is emitted after release.
- After reset release, `a_ready`=1 in the first cycle.

## Configuration
- `TLUL_SRAM_BRIDGE_INTG_EN`: defined -> `d_user.data_intg` = `prim_secded_pkg::prim_secded_inv_39_32_enc(d_data)[38:32]` and `d_user.rsp_intg` = inverted-SECDED over response metadata, computed from FIFO output. Undefined -> both fields driven 0, no encoder instantiated.

## Test plan
- Reset: hold `rst_ni`=0 with `a_valid`=1 -> `a_ready`=0, `sram_req_o`=0, `d_valid`=0; release -> `a_ready`=1 next cycle.
- Write then read: PutFull addr 0x10, data 0xDEADBEEF, mask 0xF, source 3 -> `sram_addr_o`=4, AccessAck source 3 at N+2; Get 0x10 -> AccessAckData, `d_data`=0xDEADBEEF, `d_error`=0.
- Errors: Get addr 0x2 size 2; opcode 7; Get addr 2^(AW+2) -> no `sram_req_o`, `d_error`=1, `d_data`=0xFFFFFFFF for Gets.
- Back-pressure: `d_ready`=0, issue 6 Gets -> exactly `Depth`=4 accepted, `a_ready` low; raise `d_ready` -> 4 responses in order, remaining 2 accepted and returned.
- Throughput: `d_ready`=1, 16 back-to-back Gets -> `a_ready` never drops, one response per cycle, sources in order.
- Macro on: Get returning 0x00000000 -> `d_user.data_intg` equals encoder output for 0; macro off -> 0.
